// File: rtl/axi_stream_upsizer_pkg.sv
// Shared width helpers for the AXI-Stream upsizer: lane counter sizing and
// wide-side data/keep widths derived from the narrow width and pack ratio.
package axi_stream_upsizer_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = (value > 0) ? value - 1 : 0; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // A ratio of 1 still needs a 1-bit vector to declare, even though it is unused.
  function automatic int unsigned lane_cnt_width(input int unsigned ratio);
    return (clog2(ratio) > 0) ? clog2(ratio) : 1;
  endfunction

  function automatic int unsigned m_data_width(input int unsigned s_data_width,
                                               input int unsigned ratio);
    return s_data_width * ratio;
  endfunction

  function automatic int unsigned m_keep_width(input int unsigned s_data_width,
                                               input int unsigned ratio);
    return (s_data_width * ratio) / 8;
  endfunction

endpackage

// File: rtl/axi_stream_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats (lane 0 in LSBs) into one
// registered wide beat, flushing early on tlast; flags tdest/tid changes mid-word.
module axi_stream_upsizer
  import axi_stream_upsizer_pkg::*;
#(
  parameter int unsigned S_DATA_WIDTH = 8,
  parameter int unsigned RATIO        = 4,
  parameter int unsigned USER_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH   = 1,
  parameter int unsigned ID_WIDTH     = 1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [S_DATA_WIDTH-1:0]                     s_tdata,
  input  logic                                        s_tvalid,
  output logic                                        s_tready,
  input  logic                                        s_tlast,
  input  logic [S_DATA_WIDTH/8-1:0]                   s_tstrb,
  input  logic [S_DATA_WIDTH/8-1:0]                   s_tkeep,
  input  logic [USER_WIDTH-1:0]                       s_tuser,
  input  logic [DEST_WIDTH-1:0]                       s_tdest,
  input  logic [ID_WIDTH-1:0]                         s_tid,
  output logic [m_data_width(S_DATA_WIDTH, RATIO)-1:0] m_tdata,
  output logic                                        m_tvalid,
  input  logic                                        m_tready,
  output logic                                        m_tlast,
  output logic [m_keep_width(S_DATA_WIDTH, RATIO)-1:0] m_tstrb,
  output logic [m_keep_width(S_DATA_WIDTH, RATIO)-1:0] m_tkeep,
  output logic [USER_WIDTH*RATIO-1:0]                 m_tuser,
  output logic [DEST_WIDTH-1:0]                       m_tdest,
  output logic [ID_WIDTH-1:0]                         m_tid,
  output logic                                        err_sideband
);

  localparam int unsigned M_DATA_WIDTH = m_data_width(S_DATA_WIDTH, RATIO);
  localparam int unsigned S_KEEP_WIDTH = S_DATA_WIDTH / 8;
  localparam int unsigned M_KEEP_WIDTH = m_keep_width(S_DATA_WIDTH, RATIO);
  localparam int unsigned M_USER_WIDTH = USER_WIDTH * RATIO;

  logic                    w_accept;
  logic                    w_complete;
  logic                    w_last_lane;
  logic                    w_err_set;
  logic [M_DATA_WIDTH-1:0] w_word_data;
  logic [M_KEEP_WIDTH-1:0] w_word_strb;
  logic [M_KEEP_WIDTH-1:0] w_word_keep;
  logic [M_USER_WIDTH-1:0] w_word_user;
  logic [DEST_WIDTH-1:0]   w_word_dest;
  logic [ID_WIDTH-1:0]     w_word_id;

  logic                    r_m_tvalid;
  logic                    r_m_tlast;
  logic [M_DATA_WIDTH-1:0] r_m_tdata;
  logic [M_KEEP_WIDTH-1:0] r_m_tstrb;
  logic [M_KEEP_WIDTH-1:0] r_m_tkeep;
  logic [M_USER_WIDTH-1:0] r_m_tuser;
  logic [DEST_WIDTH-1:0]   r_m_tdest;
  logic [ID_WIDTH-1:0]     r_m_tid;
  logic                    r_err;

  assign s_tready   = !r_m_tvalid || m_tready;
  assign w_accept   = s_tvalid && s_tready;
  assign w_complete = w_accept && (w_last_lane || s_tlast);

  generate
    if (RATIO == 1) begin : g_slice
      assign w_last_lane = 1'b1;
      assign w_err_set   = 1'b0;
      assign w_word_data = s_tdata;
      assign w_word_strb = s_tstrb;
      assign w_word_keep = s_tkeep;
      assign w_word_user = s_tuser;
      assign w_word_dest = s_tdest;
      assign w_word_id   = s_tid;
    end else begin : g_pack
      localparam int unsigned LANE_W = lane_cnt_width(RATIO);

      logic [LANE_W-1:0]       r_lane_cnt;
      logic [M_DATA_WIDTH-1:0] r_asm_data;
      logic [M_KEEP_WIDTH-1:0] r_asm_strb;
      logic [M_KEEP_WIDTH-1:0] r_asm_keep;
      logic [M_USER_WIDTH-1:0] r_asm_user;
      logic [DEST_WIDTH-1:0]   r_asm_dest;
      logic [ID_WIDTH-1:0]     r_asm_id;

      assign w_last_lane = (r_lane_cnt == LANE_W'(RATIO - 1));
      assign w_word_dest = (r_lane_cnt == '0) ? s_tdest : r_asm_dest;
      assign w_word_id   = (r_lane_cnt == '0) ? s_tid   : r_asm_id;
      assign w_err_set   = w_accept && (r_lane_cnt != '0) &&
                           ((s_tdest != r_asm_dest) || (s_tid != r_asm_id));

      // Word as it would look with the current beat dropped into its lane;
      // lanes above lane_cnt are already zero because assembly clears on completion.
      always_comb begin
        w_word_data = r_asm_data;
        w_word_strb = r_asm_strb;
        w_word_keep = r_asm_keep;
        w_word_user = r_asm_user;
        for (int unsigned l = 0; l < RATIO; l++) begin
          if (r_lane_cnt == LANE_W'(l)) begin
            w_word_data[l*S_DATA_WIDTH +: S_DATA_WIDTH] = s_tdata;
            w_word_strb[l*S_KEEP_WIDTH +: S_KEEP_WIDTH] = s_tstrb;
            w_word_keep[l*S_KEEP_WIDTH +: S_KEEP_WIDTH] = s_tkeep;
            w_word_user[l*USER_WIDTH +: USER_WIDTH]     = s_tuser;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_lane_cnt <= '0;
          r_asm_data <= '0;
          r_asm_strb <= '0;
          r_asm_keep <= '0;
          r_asm_user <= '0;
          r_asm_dest <= '0;
          r_asm_id   <= '0;
        end else if (w_accept) begin
          if (w_complete) begin
            r_lane_cnt <= '0;
            r_asm_data <= '0;
            r_asm_strb <= '0;
            r_asm_keep <= '0;
            r_asm_user <= '0;
            r_asm_dest <= '0;
            r_asm_id   <= '0;
          end else begin
            r_lane_cnt <= r_lane_cnt + LANE_W'(1);
            r_asm_data <= w_word_data;
            r_asm_strb <= w_word_strb;
            r_asm_keep <= w_word_keep;
            r_asm_user <= w_word_user;
            r_asm_dest <= w_word_dest;
            r_asm_id   <= w_word_id;
          end
        end
      end
    end
  endgenerate

  // A completing accept can only happen while the output is empty or draining,
  // so reloading here never overwrites an untransferred word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tstrb  <= '0;
      r_m_tkeep  <= '0;
      r_m_tuser  <= '0;
      r_m_tdest  <= '0;
      r_m_tid    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_complete) begin
        r_m_tvalid <= 1'b1;
        r_m_tlast  <= s_tlast;
        r_m_tdata  <= w_word_data;
        r_m_tstrb  <= w_word_strb;
        r_m_tkeep  <= w_word_keep;
        r_m_tuser  <= w_word_user;
        r_m_tdest  <= w_word_dest;
        r_m_tid    <= w_word_id;
      end else if (m_tready) begin
        r_m_tvalid <= 1'b0;
      end
      r_err <= w_err_set;
    end
  end

  assign m_tvalid     = r_m_tvalid;
  assign m_tlast      = r_m_tlast;
  assign m_tdata      = r_m_tdata;
  assign m_tstrb      = r_m_tstrb;
  assign m_tkeep      = r_m_tkeep;
  assign m_tuser      = r_m_tuser;
  assign m_tdest      = r_m_tdest;
  assign m_tid        = r_m_tid;
  assign err_sideband = r_err;

endmodule

// File: tb/tb_axi_stream_upsizer.sv
// Bench for axi_stream_upsizer: a RATIO=4 instance and a RATIO=1 instance,
// each checked every cycle against a lane-array model plus literal expectations.
module tb_axi_stream_upsizer;

  localparam int unsigned R = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // RATIO = 4 instance
  logic [7:0]  a_s_tdata = '0;
  logic        a_s_tvalid = 1'b0, a_s_tready, a_s_tlast = 1'b0;
  logic [0:0]  a_s_tstrb = '0, a_s_tkeep = '0, a_s_tuser = '0, a_s_tid = '0;
  logic [1:0]  a_s_tdest = '0;
  logic [31:0] a_m_tdata;
  logic        a_m_tvalid, a_m_tready = 1'b1, a_m_tlast, a_err;
  logic [3:0]  a_m_tstrb, a_m_tkeep, a_m_tuser;
  logic [1:0]  a_m_tdest;
  logic [0:0]  a_m_tid;

  // RATIO = 1 instance
  logic [7:0]  b_s_tdata = '0;
  logic        b_s_tvalid = 1'b0, b_s_tready, b_s_tlast = 1'b0;
  logic [0:0]  b_s_tstrb = '0, b_s_tkeep = '0, b_s_tuser = '0, b_s_tdest = '0, b_s_tid = '0;
  logic [7:0]  b_m_tdata;
  logic        b_m_tvalid, b_m_tready = 1'b1, b_m_tlast, b_err;
  logic [0:0]  b_m_tstrb, b_m_tkeep, b_m_tuser, b_m_tdest, b_m_tid;

  axi_stream_upsizer #(
    .S_DATA_WIDTH(8), .RATIO(4), .USER_WIDTH(1), .DEST_WIDTH(2), .ID_WIDTH(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tready(a_s_tready), .s_tlast(a_s_tlast),
    .s_tstrb(a_s_tstrb), .s_tkeep(a_s_tkeep), .s_tuser(a_s_tuser), .s_tdest(a_s_tdest),
    .s_tid(a_s_tid),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(a_m_tready), .m_tlast(a_m_tlast),
    .m_tstrb(a_m_tstrb), .m_tkeep(a_m_tkeep), .m_tuser(a_m_tuser), .m_tdest(a_m_tdest),
    .m_tid(a_m_tid), .err_sideband(a_err)
  );

  axi_stream_upsizer #(
    .S_DATA_WIDTH(8), .RATIO(1), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tlast(b_s_tlast),
    .s_tstrb(b_s_tstrb), .s_tkeep(b_s_tkeep), .s_tuser(b_s_tuser), .s_tdest(b_s_tdest),
    .s_tid(b_s_tid),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tlast(b_m_tlast),
    .m_tstrb(b_m_tstrb), .m_tkeep(b_m_tkeep), .m_tuser(b_m_tuser), .m_tdest(b_m_tdest),
    .m_tid(b_m_tid), .err_sideband(b_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of the RATIO=4 instance: narrow beats collected per lane, emitted as a word.
  int unsigned ma_cnt;
  logic [7:0]  ma_data [R];
  logic        ma_keep [R];
  logic        ma_strb [R];
  logic        ma_user [R];
  logic [1:0]  ma_dest;
  logic [0:0]  ma_id;
  logic        ma_acc;
  logic        ea_valid, ea_last, ea_err;
  logic [31:0] ea_data;
  logic [3:0]  ea_keep, ea_strb, ea_user;
  logic [1:0]  ea_dest;
  logic [0:0]  ea_id;

  // Model of the RATIO=1 instance.
  logic        mb_acc, eb_valid, eb_last;
  logic [7:0]  eb_data;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ma_cnt = 0; ea_valid = 0; ea_last = 0; ea_err = 0; ea_data = '0;
        ea_keep = '0; ea_strb = '0; ea_user = '0; ea_dest = '0; ea_id = '0;
        ma_dest = '0; ma_id = '0;
        eb_valid = 0; eb_last = 0; eb_data = '0;
      end else begin
        ma_acc = a_s_tvalid && (!ea_valid || a_m_tready);
        ea_err = 0;
        if (ea_valid && a_m_tready) ea_valid = 0;
        if (ma_acc) begin
          if (ma_cnt == 0) begin
            ma_dest = a_s_tdest;
            ma_id   = a_s_tid;
          end else if (a_s_tdest != ma_dest || a_s_tid != ma_id) begin
            ea_err = 1;
          end
          ma_data[ma_cnt] = a_s_tdata;
          ma_keep[ma_cnt] = a_s_tkeep[0];
          ma_strb[ma_cnt] = a_s_tstrb[0];
          ma_user[ma_cnt] = a_s_tuser[0];
          if (ma_cnt == R - 1 || a_s_tlast) begin
            ea_data = '0; ea_keep = '0; ea_strb = '0; ea_user = '0;
            for (int unsigned i = 0; i <= ma_cnt; i++) begin
              ea_data = ea_data | (32'(ma_data[i]) << (8 * i));
              ea_keep[i] = ma_keep[i];
              ea_strb[i] = ma_strb[i];
              ea_user[i] = ma_user[i];
            end
            ea_valid = 1; ea_last = a_s_tlast; ea_dest = ma_dest; ea_id = ma_id;
            ma_cnt = 0;
          end else begin
            ma_cnt++;
          end
        end
        mb_acc = b_s_tvalid && (!eb_valid || b_m_tready);
        if (eb_valid && b_m_tready) eb_valid = 0;
        if (mb_acc) begin
          eb_valid = 1; eb_data = b_s_tdata; eb_last = b_s_tlast;
        end
      end
    end
  end

  logic [31:0] got_a [$];
  logic [7:0]  got_b [$];
  int unsigned n_err_a = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_a_m_tvalid", a_m_tvalid, 0);
        check("rst_a_m_tlast", a_m_tlast, 0);
        check("rst_a_m_tdata", a_m_tdata, 0);
        check("rst_a_m_tkeep", {a_m_tkeep, a_m_tstrb, a_m_tuser}, 0);
        check("rst_a_m_tdest_tid", {a_m_tdest, a_m_tid}, 0);
        check("rst_a_err", a_err, 0);
        check("rst_a_s_tready", a_s_tready, 1);
        check("rst_b_m_tvalid", b_m_tvalid, 0);
        check("rst_b_m_tdata", b_m_tdata, 0);
      end else begin
        check("a_s_tready", a_s_tready, !ea_valid || a_m_tready);
        check("a_m_tvalid", a_m_tvalid, ea_valid);
        check("a_err_sideband", a_err, ea_err);
        if (ea_valid) begin
          check("a_m_tdata", a_m_tdata, ea_data);
          check("a_m_tkeep", a_m_tkeep, ea_keep);
          check("a_m_tstrb", a_m_tstrb, ea_strb);
          check("a_m_tuser", a_m_tuser, ea_user);
          check("a_m_tlast", a_m_tlast, ea_last);
          check("a_m_tdest", a_m_tdest, ea_dest);
          check("a_m_tid", a_m_tid, ea_id);
        end
        if (a_m_tvalid && a_m_tready) got_a.push_back(a_m_tdata);
        if (a_err) n_err_a++;
        check("b_s_tready", b_s_tready, !eb_valid || b_m_tready);
        check("b_m_tvalid", b_m_tvalid, eb_valid);
        if (eb_valid) begin
          check("b_m_tdata", b_m_tdata, eb_data);
          check("b_m_tlast", b_m_tlast, eb_last);
        end
        if (b_m_tvalid && b_m_tready) got_b.push_back(b_m_tdata);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_a(input logic [7:0] d, input logic l, input logic k,
                        input logic u, input logic [1:0] dst);
    int unsigned t;
    a_s_tdata = d; a_s_tlast = l; a_s_tkeep = k; a_s_tstrb = k;
    a_s_tuser = u; a_s_tdest = dst; a_s_tid = '0; a_s_tvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (a_s_tready) break;
      t++;
      if (t > 50) begin
        check("a_send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic l);
    int unsigned t;
    b_s_tdata = d; b_s_tlast = l; b_s_tkeep = 1'b1; b_s_tstrb = 1'b1; b_s_tvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (b_s_tready) break;
      t++;
      if (t > 50) begin
        check("b_send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n0, e0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_s_tready", a_s_tready, 1);
    check("post_rst_m_tvalid", a_m_tvalid, 0);

    // Full word, tlast on the fourth beat, tuser per lane
    send_a(8'h11, 0, 1, 1, 2'd0);
    send_a(8'h22, 0, 1, 0, 2'd0);
    send_a(8'h33, 0, 1, 1, 2'd0);
    send_a(8'h44, 1, 1, 1, 2'd0);
    @(negedge clk);
    check("t1_valid", a_m_tvalid, 1);
    check("t1_data", a_m_tdata, 32'h44332211);
    check("t1_keep", a_m_tkeep, 4'hF);
    check("t1_last", a_m_tlast, 1);
    check("t1_user", a_m_tuser, 4'hD);
    @(posedge clk); #1;

    // Early flush on tlast with two lanes filled
    send_a(8'hAA, 0, 1, 0, 2'd0);
    send_a(8'hBB, 1, 1, 0, 2'd0);
    @(negedge clk);
    check("t2_data", a_m_tdata, 32'h0000BBAA);
    check("t2_keep", a_m_tkeep, 4'h3);
    check("t2_strb", a_m_tstrb, 4'h3);
    check("t2_last", a_m_tlast, 1);
    @(posedge clk); #1;

    // Backpressure: eight beats, m_tready held low after the first word forms
    n0 = got_a.size();
    a_m_tready = 1'b0;
    fork
      for (int i = 0; i < 8; i++) send_a(8'(i + 1), 0, 1, 0, 2'd0);
      begin
        repeat (8) @(posedge clk);
        #1;
        check("t3_stall_s_tready", a_s_tready, 0);
        check("t3_hold_data", a_m_tdata, 32'h04030201);
        a_m_tready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;
    check("t3_word_count", got_a.size() - n0, 2);
    check("t3_word0", got_a[n0], 32'h04030201);
    check("t3_word1", got_a[n0 + 1], 32'h08070605);

    // Reset mid-word discards the partial assembly
    send_a(8'hE1, 0, 1, 0, 2'd0);
    send_a(8'hE2, 0, 1, 0, 2'd0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("t4_rst_valid", a_m_tvalid, 0);
    check("t4_rst_s_tready", a_s_tready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_a(8'h55, 0, 1, 0, 2'd0);
    send_a(8'h66, 0, 1, 0, 2'd0);
    send_a(8'h77, 0, 1, 0, 2'd0);
    send_a(8'h88, 1, 1, 0, 2'd0);
    @(negedge clk);
    check("t4_data", a_m_tdata, 32'h88776655);
    check("t4_keep", a_m_tkeep, 4'hF);
    @(posedge clk); #1;

    // tdest change on lane 2
    e0 = n_err_a;
    send_a(8'h10, 0, 1, 0, 2'd1);
    send_a(8'h20, 0, 1, 0, 2'd1);
    send_a(8'h30, 0, 1, 0, 2'd2);
    send_a(8'h40, 1, 1, 0, 2'd1);
    @(negedge clk);
    check("t5_dest", a_m_tdest, 2'd1);
    check("t5_data", a_m_tdata, 32'h40302010);
    @(posedge clk); #1;
    check("t5_err_pulses", n_err_a - e0, 1);

    // Back-to-back tlast beats and an all-zero tkeep beat occupying a lane
    n0 = got_a.size();
    send_a(8'hC1, 1, 1, 0, 2'd0);
    send_a(8'hC2, 1, 1, 0, 2'd0);
    send_a(8'hC3, 1, 1, 0, 2'd0);
    send_a(8'hD1, 0, 0, 0, 2'd0);
    send_a(8'hD2, 1, 1, 0, 2'd0);
    @(negedge clk);
    check("t6_zero_keep_data", a_m_tdata, 32'h0000D2D1);
    check("t6_zero_keep_keep", a_m_tkeep, 4'h2);
    @(posedge clk); #1;
    check("t6_word_count", got_a.size() - n0, 4);
    check("t6_word2", got_a[n0 + 2], 32'h000000C3);

    // RATIO = 1 register slice with m_tready toggling every cycle
    n0 = got_b.size();
    fork
      for (int i = 0; i < 10; i++) send_b(8'(8'hA0 + i), (i == 9));
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        b_m_tready = ~b_m_tready;
      end
    join
    b_m_tready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("t7_count", got_b.size() - n0, 10);
    for (int i = 0; i < 10; i++) check("t7_order", got_b[n0 + i], 8'(8'hA0 + i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_stream_upsizer.md
# axi_stream_upsizer

AXI-Stream width upsizer that packs RATIO consecutive narrow beats into one wide beat. It sits directly upstream of the AXI-Stream pass-through interface and drives its slave port at the wide width. A wide beat is emitted when all lanes are filled, or early when a narrow beat carries tlast. Output is registered, and full throughput is sustained when downstream is always ready.

## Interface
- S_DATA_WIDTH, 8: narrow input data width; multiple of 8.
- RATIO, 4: narrow beats per wide beat; integer ≥ 1. M_DATA_WIDTH = S_DATA_WIDTH*RATIO.
- USER_WIDTH, 1: per-narrow-beat tuser width.
- DEST_WIDTH, 1: tdest width.
- ID_WIDTH, 1: tid width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_tdata  in  S_DATA_WIDTH  narrow data.
- s_tvalid  in  1; s_tready  out  1; s_tlast  in  1.
- s_tstrb, s_tkeep  in  S_DATA_WIDTH/8  narrow byte qualifiers.
- s_tuser  in  USER_WIDTH; s_tdest  in  DEST_WIDTH; s_tid  in  ID_WIDTH.
- m_tdata  out  M_DATA_WIDTH  wide data; lane 0 (first beat) in LSBs.
- m_tvalid  out  1; m_tready  in  1; m_tlast  out  1.
- m_tstrb, m_tkeep  out  M_DATA_WIDTH/8  per-lane concatenation.
- m_tuser  out  USER_WIDTH*RATIO  per-lane tuser concatenation, lane 0 in LSBs.
- m_tdest  out  DEST_WIDTH; m_tid  out  ID_WIDTH.
- err_sideband  out  1  one-cycle pulse on a sideband violation.

## Operation
- Narrow accept: s_tvalid && s_tready. Wide transfer: m_tvalid && m_tready.
- s_tready = !m_tvalid || m_tready. This is combinational from m_tready only, never from s_* inputs.
- Lane counter lane_cnt (0..RATIO-1):
  - An accepted beat is written into lane lane_cnt of the assembly registers: data, strb, keep, user.
  - A beat with all-zero tkeep still occupies a lane.
- Word completion: an accepted beat with lane_cnt == RATIO-1 or with s_tlast = 1. On completion:
  - The assembled word, including the current beat, loads the output register.
  - m_tlast is set to s_tlast.
  - Unfilled higher lanes output tdata/tstrb/tkeep/tuser = 0.
  - lane_cnt returns to 0 and the assembly registers clear.
- Non-completing accept: the beat is written and lane_cnt increments.
- Sideband rules:
  - tdest/tid are captured on lane 0 of each word and presented with that word.
  - If a later beat in the same word carries a different tdest or tid, err_sideband pulses for one cycle. The beat is still packed and the captured value is kept.
- RATIO = 1: every accepted beat completes a word. The block then behaves as a one-stage register slice.

## Timing
- Reset (async, rst_n = 0):
  - m_tvalid = 0, m_tlast = 0, m_tdata/m_tstrb/m_tkeep/m_tuser/m_tdest/m_tid = 0.
  - err_sideband = 0, lane_cnt = 0, assembly registers cleared.
  - s_tready = 1 out of reset.
- Latency: m_tvalid rises on the cycle after the completing narrow accept.
- m_tvalid stays high and all m_* remain stable until m_tready.
- Simultaneous wide transfer and completing accept: the output register reloads in the same edge, so m_tvalid stays high with no bubble.
- When m_tvalid && !m_tready:
  - s_tready = 0, so no accepts occur, including non-completing ones.
  - The partially assembled word is held untouched.
- Reset mid-word: the partial word is discarded. The first beat after reset lands in lane 0.
- Back-to-back narrow tlast beats: each produces its own wide word with tkeep on lane 0 only.

## Structure
- Shared package/header: a clog2 function for the lane_cnt width, plus derived constants M_DATA_WIDTH and M_KEEP_WIDTH.
- Single module. The output register is inline, with no sub-module.
- An optional generate branch handles RATIO == 1, where lane_cnt is absent.

## Test plan
- S=8, R=4: beats 0x11, 0x22, 0x33, 0x44 with tlast on 0x44 → one wide beat: tdata 0x44332211, tkeep 0xF, tlast 1, one cycle after the fourth accept.
- Beats 0xAA, 0xBB with tlast on 0xBB → tdata 0x0000BBAA, tkeep 0x3, tstrb 0x3, tlast 1.
- Continuous valid with m_tready held 0 after the first word → s_tready drops. The word is held stable, and no data is lost when m_tready returns. Eight beats yield exactly two words in order.
- Assert rst_n = 0 after two of four beats, then send 0x55..0x88 → all outputs are 0 during reset. The next word is 0x88776655 with no remnant of the earlier beats.
- tdest 1 on lane 0 and tdest 2 on lane 2 → err_sideband pulses once, and the word carries m_tdest = 1.
- RATIO = 1, with m_tready toggled every cycle → each input appears on m_tdata one cycle later, with no drop and no duplicate.
